// File: rtl/procyon_ifq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : procyon_ifq
//  Purpose  : Instruction fetch miss queue. Collects line-aligned miss
//             addresses in a small circular FIFO (merging duplicates),
//             issues one memory line read at a time in allocation order and
//             presents each returned line as a single-cycle fill strobe.
//  Ports    :
//    clk               clock
//    rst               synchronous active-high reset
//    i_alloc_en        fetch miss request
//    i_alloc_addr      miss PC (low line-offset bits ignored)
//    o_ifq_full        queue holds OPTN_IFQ_DEPTH entries
//    o_mem_req_en      line read request (REQ state)
//    o_mem_req_addr    line-aligned request address (head entry)
//    i_mem_req_ack     request accepted by memory
//    i_mem_rsp_valid   line data returned
//    i_mem_rsp_data    returned line data
//    o_fill_en         icache/fetch fill strobe (FILL state)
//    o_fill_addr       line-aligned fill address
//    o_fill_data       fill line
//  Revision : 1.0 - initial release
// ============================================================================
module procyon_ifq #(
    parameter int OPTN_ADDR_WIDTH   = 32,
    parameter int OPTN_IC_LINE_SIZE = 32,
    parameter int OPTN_IFQ_DEPTH    = 4,
    parameter int IC_LINE_WIDTH     = OPTN_IC_LINE_SIZE * 8
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       i_alloc_en,
    input  logic [OPTN_ADDR_WIDTH-1:0] i_alloc_addr,
    output logic                       o_ifq_full,

    output logic                       o_mem_req_en,
    output logic [OPTN_ADDR_WIDTH-1:0] o_mem_req_addr,
    input  logic                       i_mem_req_ack,
    input  logic                       i_mem_rsp_valid,
    input  logic [IC_LINE_WIDTH-1:0]   i_mem_rsp_data,

    output logic                       o_fill_en,
    output logic [OPTN_ADDR_WIDTH-1:0] o_fill_addr,
    output logic [IC_LINE_WIDTH-1:0]   o_fill_data
);

    localparam int c_PTR_W = $clog2(OPTN_IFQ_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [OPTN_ADDR_WIDTH-1:0] c_OFFS_MASK = OPTN_ADDR_WIDTH'(OPTN_IC_LINE_SIZE - 1);
    localparam logic [c_CNT_W-1:0]         c_CNT_FULL  = c_CNT_W'(OPTN_IFQ_DEPTH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_FILL = 2'd3;

    // Queue storage
    logic [OPTN_ADDR_WIDTH-1:0] r_entry_addr [OPTN_IFQ_DEPTH];
    logic [OPTN_IFQ_DEPTH-1:0]  r_entry_valid;
    logic [c_PTR_W-1:0]         r_head;
    logic [c_PTR_W-1:0]         r_tail;
    logic [c_CNT_W-1:0]         r_count;

    // Controller
    logic [1:0]                 r_state;
    logic [1:0]                 w_state_next;
    logic [OPTN_ADDR_WIDTH-1:0] r_fill_addr;
    logic [IC_LINE_WIDTH-1:0]   r_fill_data;

    logic [OPTN_ADDR_WIDTH-1:0] w_line_addr;
    logic                       w_full;
    logic                       w_in_fill;
    logic                       w_merge;
    logic                       w_push;
    logic                       w_pop;

    assign w_line_addr = i_alloc_addr & ~c_OFFS_MASK;
    assign w_full      = (r_count == c_CNT_FULL);
    assign w_in_fill   = (r_state == c_ST_FILL);

    // A miss to a line already queued is absorbed. The head entry being
    // filled right now is about to leave, so a fresh miss to it must be
    // queued again rather than merged.
    always_comb begin
        w_merge = 1'b0;
        for (int i = 0; i < OPTN_IFQ_DEPTH; i++) begin
            if (r_entry_valid[i] && (r_entry_addr[i] == w_line_addr) &&
                !(w_in_fill && (r_head == c_PTR_W'(i)))) begin
                w_merge = 1'b1;
            end
        end
    end

    // Full is judged on the registered count, so a pop in the same cycle
    // does not open a slot for this cycle's alloc.
    assign w_push = i_alloc_en && !w_full && !w_merge;
    assign w_pop  = w_in_fill;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entry_addr[r_tail] <= w_line_addr;
        end
    end

    // With count below depth and nonzero, head and tail never coincide, so
    // the set and clear below never target the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry_valid <= '0;
        end else begin
            if (w_push) begin
                r_entry_valid[r_tail] <= 1'b1;
            end
            if (w_pop) begin
                r_entry_valid[r_head] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (r_count != '0)     w_state_next = c_ST_REQ;
            c_ST_REQ:  if (i_mem_req_ack)     w_state_next = c_ST_WAIT;
            c_ST_WAIT: if (i_mem_rsp_valid)   w_state_next = c_ST_FILL;
            c_ST_FILL:                        w_state_next = c_ST_IDLE;
            default:                          w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The head is stable from REQ through FILL, so it names the returned line.
    always_ff @(posedge clk) begin
        if ((r_state == c_ST_WAIT) && i_mem_rsp_valid) begin
            r_fill_addr <= r_entry_addr[r_head];
            r_fill_data <= i_mem_rsp_data;
        end
    end

    assign o_ifq_full     = w_full;
    assign o_mem_req_en   = (r_state == c_ST_REQ);
    assign o_mem_req_addr = r_entry_addr[r_head];
    assign o_fill_en      = w_in_fill;
    assign o_fill_addr    = r_fill_addr;
    assign o_fill_data    = r_fill_data;

endmodule
`default_nettype wire

// File: tb/tb_procyon_ifq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_procyon_ifq
//  Purpose  : Self-checking bench for procyon_ifq. Expected requests and
//             fills are queued as stimulus is applied and consumed by a
//             monitor as the design produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_procyon_ifq;

    localparam int c_AW = 32;
    localparam int c_LS = 32;
    localparam int c_LW = c_LS * 8;

    logic            clk;
    logic            rst;
    logic            i_alloc_en;
    logic [c_AW-1:0] i_alloc_addr;
    logic            o_ifq_full;
    logic            o_mem_req_en;
    logic [c_AW-1:0] o_mem_req_addr;
    logic            i_mem_req_ack;
    logic            i_mem_rsp_valid;
    logic [c_LW-1:0] i_mem_rsp_data;
    logic            o_fill_en;
    logic [c_AW-1:0] o_fill_addr;
    logic [c_LW-1:0] o_fill_data;

    procyon_ifq #(
        .OPTN_ADDR_WIDTH   (c_AW),
        .OPTN_IC_LINE_SIZE (c_LS),
        .OPTN_IFQ_DEPTH    (4),
        .IC_LINE_WIDTH     (c_LW)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .i_alloc_en      (i_alloc_en),
        .i_alloc_addr    (i_alloc_addr),
        .o_ifq_full      (o_ifq_full),
        .o_mem_req_en    (o_mem_req_en),
        .o_mem_req_addr  (o_mem_req_addr),
        .i_mem_req_ack   (i_mem_req_ack),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .i_mem_rsp_data  (i_mem_rsp_data),
        .o_fill_en       (o_fill_en),
        .o_fill_addr     (o_fill_addr),
        .o_fill_data     (o_fill_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total;
    int n_bad;

    logic [c_AW-1:0] req_q[$];
    logic [c_AW-1:0] fill_addr_q[$];
    logic [c_LW-1:0] fill_data_q[$];

    bit              mon_new_req;
    logic [c_AW-1:0] mon_held_addr;

    task automatic check(input string tag, input logic [c_LW-1:0] obs, input logic [c_LW-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [c_LW-1:0] pat(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [c_AW-1:0] a, input bit accept);
        i_alloc_en   = 1'b1;
        i_alloc_addr = a;
        if (accept) req_q.push_back(a & ~32'h1F);
        tick();
        i_alloc_en   = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (o_mem_req_en) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("req_timeout", c_LW'(o_mem_req_en), c_LW'(1));
    endtask

    task automatic idle_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check(tag, c_LW'(o_mem_req_en), c_LW'(0));
            tick();
        end
    endtask

    // Service the next request: optional ack delay (with an optional stray
    // response during REQ), response on the first WAIT cycle, and an
    // optional alloc driven during the FILL cycle.
    task automatic serve(input logic [c_AW-1:0] exp_addr, input int delay,
                         input logic [c_LW-1:0] data, input bit spurious,
                         input bit fa_en, input logic [c_AW-1:0] fa_addr,
                         input bit fa_accept);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        for (int i = 0; i < delay; i++) begin
            i_mem_rsp_valid = spurious && (i == 0);
            i_mem_rsp_data  = ~data;
            check("req_held", c_LW'(o_mem_req_en), c_LW'(1));
            tick();
        end
        i_mem_rsp_valid = 1'b0;
        i_mem_req_ack   = 1'b1;
        check("req_at_ack", c_LW'(o_mem_req_en), c_LW'(1));
        tick();
        i_mem_req_ack   = 1'b0;
        check("wait_no_req", c_LW'(o_mem_req_en), c_LW'(0));
        check("wait_no_fill", c_LW'(o_fill_en), c_LW'(0));
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = data;
        fill_addr_q.push_back(exp_addr);
        fill_data_q.push_back(data);
        tick();
        i_mem_rsp_valid = 1'b0;
        check("fill_en", c_LW'(o_fill_en), c_LW'(1));
        if (fa_en) begin
            i_alloc_en   = 1'b1;
            i_alloc_addr = fa_addr;
            if (fa_accept) req_q.push_back(fa_addr & ~32'h1F);
        end
        tick();
        i_alloc_en = 1'b0;
        check("fill_one_cycle", c_LW'(o_fill_en), c_LW'(0));
    endtask

    // Output monitor: every new request and every fill must match the head
    // of its expectation queue; a request must hold its address until acked.
    initial begin
        mon_new_req   = 1'b1;
        mon_held_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_new_req = 1'b1;
            end else begin
                if (o_mem_req_en) begin
                    if (mon_new_req) begin
                        check("req_expected", c_LW'(req_q.size() != 0), c_LW'(1));
                        if (req_q.size() != 0) begin
                            check("req_addr", c_LW'(o_mem_req_addr), c_LW'(req_q[0]));
                            void'(req_q.pop_front());
                        end
                        mon_held_addr = o_mem_req_addr;
                        mon_new_req   = 1'b0;
                    end else begin
                        check("req_stable", c_LW'(o_mem_req_addr), c_LW'(mon_held_addr));
                    end
                    if (i_mem_req_ack) mon_new_req = 1'b1;
                end
                if (o_fill_en) begin
                    check("fill_expected", c_LW'(fill_addr_q.size() != 0), c_LW'(1));
                    if (fill_addr_q.size() != 0) begin
                        check("fill_addr", c_LW'(o_fill_addr), c_LW'(fill_addr_q[0]));
                        check("fill_data", o_fill_data, fill_data_q[0]);
                        void'(fill_addr_q.pop_front());
                        void'(fill_data_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit ok;
        n_total         = 0;
        n_bad           = 0;
        rst             = 1'b1;
        i_alloc_en      = 1'b0;
        i_alloc_addr    = '0;
        i_mem_req_ack   = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data  = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_full", c_LW'(o_ifq_full), c_LW'(0));
        check("rst_req", c_LW'(o_mem_req_en), c_LW'(0));
        check("rst_fill", c_LW'(o_fill_en), c_LW'(0));
        tick();

        // Single miss with minimum latency
        i_alloc_en   = 1'b1;
        i_alloc_addr = 32'h0000_1004;
        req_q.push_back(32'h0000_1000);
        tick();
        i_alloc_en = 1'b0;
        check("s1_n1_noreq", c_LW'(o_mem_req_en), c_LW'(0));
        tick();
        check("s1_n2_req", c_LW'(o_mem_req_en), c_LW'(1));
        check("s1_n2_addr", c_LW'(o_mem_req_addr), c_LW'(32'h0000_1000));
        i_mem_req_ack = 1'b1;
        tick();
        i_mem_req_ack = 1'b0;
        check("s1_n3_noreq", c_LW'(o_mem_req_en), c_LW'(0));
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = pat(8'hAB);
        fill_addr_q.push_back(32'h0000_1000);
        fill_data_q.push_back(pat(8'hAB));
        tick();
        i_mem_rsp_valid = 1'b0;
        check("s1_n4_fill", c_LW'(o_fill_en), c_LW'(1));
        check("s1_n4_addr", c_LW'(o_fill_addr), c_LW'(32'h0000_1000));
        check("s1_n4_data", o_fill_data, pat(8'hAB));
        tick();
        check("s1_n5_nofill", c_LW'(o_fill_en), c_LW'(0));
        idle_check("s1_idle", 3);

        // Merge of a second miss to the same line
        alloc(32'h0000_2000, 1'b1);
        alloc(32'h0000_201C, 1'b0);
        serve(32'h0000_2000, 0, pat(8'h20), 1'b0, 1'b0, '0, 1'b0);
        idle_check("s2_single_req", 4);

        // Fill the queue, drop extra allocs (including one during a pop)
        alloc(32'h0000_0000, 1'b1);
        alloc(32'h0000_0020, 1'b1);
        alloc(32'h0000_0040, 1'b1);
        check("s3_not_full", c_LW'(o_ifq_full), c_LW'(0));
        alloc(32'h0000_0060, 1'b1);
        check("s3_full", c_LW'(o_ifq_full), c_LW'(1));
        alloc(32'h0000_0080, 1'b0);
        check("s3_still_full", c_LW'(o_ifq_full), c_LW'(1));
        serve(32'h0000_0000, 3, pat(8'h01), 1'b0, 1'b1, 32'h0000_00A0, 1'b0);
        check("s3_after_pop", c_LW'(o_ifq_full), c_LW'(0));
        serve(32'h0000_0020, 0, pat(8'h02), 1'b0, 1'b0, '0, 1'b0);
        serve(32'h0000_0040, 0, pat(8'h03), 1'b0, 1'b0, '0, 1'b0);
        serve(32'h0000_0060, 0, pat(8'h04), 1'b0, 1'b0, '0, 1'b0);
        idle_check("s3_drained", 4);

        // Re-miss on the line currently being filled
        alloc(32'h0000_3000, 1'b1);
        serve(32'h0000_3000, 0, pat(8'h30), 1'b0, 1'b1, 32'h0000_3000, 1'b1);
        serve(32'h0000_3000, 0, pat(8'h31), 1'b0, 1'b0, '0, 1'b0);
        idle_check("s4_idle", 3);

        // Long ack stall with a stray response while requesting
        alloc(32'h0000_4010, 1'b1);
        serve(32'h0000_4000, 10, pat(8'h44), 1'b1, 1'b0, '0, 1'b0);
        idle_check("s5_idle", 3);

        // Reset while waiting for data, then a late response
        alloc(32'h0000_5008, 1'b1);
        wait_req(ok);
        i_mem_req_ack = 1'b1;
        tick();
        i_mem_req_ack = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s6_rst_full", c_LW'(o_ifq_full), c_LW'(0));
        check("s6_rst_req", c_LW'(o_mem_req_en), c_LW'(0));
        check("s6_rst_fill", c_LW'(o_fill_en), c_LW'(0));
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = pat(8'h55);
        tick();
        i_mem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("s6_no_fill", c_LW'(o_fill_en), c_LW'(0));
            check("s6_no_req", c_LW'(o_mem_req_en), c_LW'(0));
            check("s6_not_full", c_LW'(o_ifq_full), c_LW'(0));
            tick();
        end

        check("req_q_drained", c_LW'(req_q.size()), c_LW'(0));
        check("fill_q_drained", c_LW'(fill_addr_q.size()), c_LW'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
